// File: rtl/ebpc_pkg.sv
// rtl/ebpc_pkg.sv - shared types and constants for the EBPC output path
//
// DATA_W         : word width of every EBPC data port
// HDR_CNT_W      : width of the payload-count field in a merged-stream header
// stream_id_t    : which encoder stream a frame carries (header MSB)
// merger_state_t : stream merger framing states
package ebpc_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned HDR_CNT_W = DATA_W - 1;

  typedef enum logic {
    STREAM_ZNZ = 1'b0,
    STREAM_BPC = 1'b1
  } stream_id_t;

  typedef enum logic [1:0] {
    SEL,
    HDR,
    PAY
  } merger_state_t;

endpackage

// File: rtl/ebpc_sync_fifo.sv
// rtl/ebpc_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (empties the FIFO)
//   push_i         write push_data_i; ignored while full_o
//   push_data_i    word to write
//   pop_i          drop the head word; must not be raised while empty_o
//   head_o         current head word (valid while !empty_o)
//   full_o         occ_o == DEPTH
//   empty_o        occ_o == 0
//   occ_o          number of stored words
module ebpc_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop happens in the same cycle;
  // the freed slot only becomes writable on the following cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/ebpc_stream_merger.sv
// rtl/ebpc_stream_merger.sv - merges EBPC ZNZ and BPC streams into one framed stream
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   znz_data_i/_vld_i/_rdy_o ZNZ input stream (rdy = ZNZ FIFO not full)
//   bpc_data_i/_vld_i/_rdy_o BPC input stream (rdy = BPC FIFO not full)
//   enc_idle_i               encoder drained; allows short flush frames
//   data_o/vld_o/rdy_i       merged output stream: header {id, cnt}, then cnt payload words
//   last_o                   final payload word of a frame
//   idle_o                   both FIFOs empty and no frame in progress
module ebpc_stream_merger
  import ebpc_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  input  logic              enc_idle_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              last_o,
  output logic              idle_o
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0]     BURST_OCC = OCC_W'(BURST_LEN);
  localparam logic [HDR_CNT_W-1:0] BURST_CNT = HDR_CNT_W'(BURST_LEN);

  logic [DATA_W-1:0] znz_head, bpc_head;
  logic [OCC_W-1:0]  znz_occ, bpc_occ;
  logic              znz_full, bpc_full;
  logic              znz_empty, bpc_empty;
  logic              znz_pop, bpc_pop;

  merger_state_t        state_q, state_d;
  stream_id_t           id_q, id_d;
  stream_id_t           rr_q, rr_d;
  logic [HDR_CNT_W-1:0] cnt_q, cnt_d;
  logic [HDR_CNT_W-1:0] rem_q, rem_d;

  logic                 flush;
  logic                 znz_elig, bpc_elig;
  stream_id_t           pick_id;
  logic [OCC_W-1:0]     pick_occ;
  logic [HDR_CNT_W-1:0] pick_cnt;

  ebpc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_znz_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (znz_vld_i),
    .push_data_i (znz_data_i),
    .pop_i       (znz_pop),
    .head_o      (znz_head),
    .full_o      (znz_full),
    .empty_o     (znz_empty),
    .occ_o       (znz_occ)
  );

  ebpc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_bpc_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (bpc_vld_i),
    .push_data_i (bpc_data_i),
    .pop_i       (bpc_pop),
    .head_o      (bpc_head),
    .full_o      (bpc_full),
    .empty_o     (bpc_empty),
    .occ_o       (bpc_occ)
  );

  // Input readiness depends only on FIFO state, never on the output side.
  assign znz_rdy_o = !znz_full;
  assign bpc_rdy_o = !bpc_full;

  // A short frame is only allowed once the encoder is idle and nothing is
  // arriving on either stream, so residual words are not split needlessly.
  assign flush    = enc_idle_i && !znz_vld_i && !bpc_vld_i;
  assign znz_elig = (znz_occ >= BURST_OCC) || (flush && !znz_empty);
  assign bpc_elig = (bpc_occ >= BURST_OCC) || (flush && !bpc_empty);

  assign pick_id  = (znz_elig && bpc_elig) ? rr_q
                  : (bpc_elig ? STREAM_BPC : STREAM_ZNZ);
  assign pick_occ = (pick_id == STREAM_BPC) ? bpc_occ : znz_occ;
  assign pick_cnt = (pick_occ >= BURST_OCC) ? BURST_CNT : HDR_CNT_W'(pick_occ);

  assign idle_o = znz_empty && bpc_empty && (state_q == SEL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEL;
      id_q    <= STREAM_ZNZ;
      rr_q    <= STREAM_ZNZ;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs are decoded from registered state and FIFO heads only, so they
  // hold steady while rdy_i is low (a FIFO head only moves on our own pop).
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    vld_o   = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    znz_pop = 1'b0;
    bpc_pop = 1'b0;

    case (state_q)
      SEL: begin
        if (znz_elig || bpc_elig) begin
          id_d    = pick_id;
          cnt_d   = pick_cnt;
          state_d = HDR;
        end
      end

      HDR: begin
        vld_o  = 1'b1;
        data_o = {id_q, cnt_q};
        if (rdy_i) begin
          rem_d   = cnt_q;
          state_d = PAY;
        end
      end

      PAY: begin
        vld_o  = 1'b1;
        data_o = (id_q == STREAM_BPC) ? bpc_head : znz_head;
        last_o = (rem_q == HDR_CNT_W'(1));
        if (rdy_i) begin
          znz_pop = (id_q == STREAM_ZNZ);
          bpc_pop = (id_q == STREAM_BPC);
          rem_d   = rem_q - HDR_CNT_W'(1);
          if (rem_q == HDR_CNT_W'(1)) begin
            state_d = SEL;
            rr_d    = (id_q == STREAM_ZNZ) ? STREAM_BPC : STREAM_ZNZ;
          end
        end
      end

      default: state_d = SEL;
    endcase
  end

  a_pay_nonempty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == PAY) |-> ((id_q == STREAM_BPC) ? !bpc_empty : !znz_empty));

endmodule

// File: doc/ebpc_stream_merger.md
Name: ebpc_stream_merger

Overview:
- Sits directly downstream of the EBPC encoder. Consumes its two output streams: ZNZ (zero/non-zero run-length) and BPC (bit-plane).
- Buffers each stream in its own FIFO and emits a single framed output stream. Each frame is one header word followed by up to BURST_LEN payload words of one stream.
- Lets the encoder attach to one memory/DMA port without either stream starving the other.

Parameters:
- DATA_W, ebpc_pkg::DATA_W (8): word width of all data ports. Taken from the package, not overridable.
- BURST_LEN, 8: maximum payload words per frame. Must satisfy 1 ≤ BURST_LEN ≤ 2^(DATA_W-1)-1.
- FIFO_DEPTH, 16: depth of each per-stream FIFO. Must be ≥ BURST_LEN and a power of two.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- znz_data_i  in  DATA_W  ZNZ stream word
- znz_vld_i  in  1  ZNZ word valid
- znz_rdy_o  out  1  ZNZ FIFO not full
- bpc_data_i  in  DATA_W  BPC stream word
- bpc_vld_i  in  1  BPC word valid
- bpc_rdy_o  out  1  BPC FIFO not full
- enc_idle_i  in  1  encoder idle (upstream fully drained)
- data_o  out  DATA_W  merged stream word
- vld_o  out  1  data_o valid
- rdy_i  in  1  downstream ready
- last_o  out  1  marks the final payload word of a frame
- idle_o  out  1  both FIFOs empty and FSM in SEL

Behaviour:
- Reset: clk_i/rst_ni are as stated in Ports.
  - FIFOs are emptied, state = SEL, round-robin pointer = ZNZ.
  - data_o = 0, vld_o = 0, last_o = 0, idle_o = 1, znz_rdy_o = 1, bpc_rdy_o = 1 (once reset is released).
  - A reset asserted mid-frame aborts the frame. Partial data is discarded and is not replayed.
- Input side:
  - x_rdy_o = !full(x). There is no combinational path from rdy_i or vld_o.
  - A push occurs on x_vld_i && x_rdy_o. The word is visible in the occupancy count the next cycle.
- Eligibility of stream x, evaluated in SEL:
  - Full burst: occ(x) ≥ BURST_LEN, or
  - Flush: enc_idle_i && occ(x) > 0 && !znz_vld_i && !bpc_vld_i.
- Frame length: cnt = min(occ(x), BURST_LEN), latched on leaving SEL.
- FSM states:
  - SEL: vld_o = 0.
    - Exactly one stream eligible: latch id and cnt, go to HDR.
    - Both eligible: pick the stream indicated by the rr pointer.
    - None eligible: stay.
  - HDR: vld_o = 1, data_o = {id, cnt[DATA_W-2:0]}, with id 0 = ZNZ and 1 = BPC.
    - On rdy_i go to PAY and load remaining = cnt.
  - PAY: vld_o = 1, data_o = head of FIFO(id).
    - On rdy_i: pop and decrement remaining.
    - last_o = (remaining == 1).
    - On the handshake with remaining == 1: go to SEL and set rr = !id.
- AXI-style hold: once vld_o is high, data_o, vld_o and last_o stay stable until rdy_i.
- Latency: minimum 1 cycle from SEL decision to header presentation (HDR registered).
  - Steady state, full-rate throughput is cnt + 1 output cycles per frame, plus one SEL cycle.
- Boundary conditions:
  - Simultaneous push and pop on a full FIFO: the pop frees space next cycle; rdy_o is still low this cycle.
  - Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged.
  - A push to the stream being popped during PAY is legal. cnt was latched, so the frame length is unaffected.
  - enc_idle_i deasserting during a flush frame: the frame completes with the latched cnt.
  - rr only flips after a completed frame.
  - Occupancy counter width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Assertions:
  - Pop on an empty FIFO is illegal.
  - In PAY, the FIFO(id) non-empty property holds by construction.

Decomposition:
- Additions to ebpc_pkg:
  - typedef enum logic {STREAM_ZNZ = 1'b0, STREAM_BPC = 1'b1} stream_id_t
  - typedef enum logic [1:0] {SEL, HDR, PAY} merger_state_t
  - constant HDR_CNT_W = DATA_W-1
- One sub-module, ebpc_sync_fifo (DATA_W, DEPTH): push/pop, full/empty, occupancy output. Instantiated twice.

Test Plan:
- Push 8 ZNZ words 0x01..0x08 with enc_idle_i=0 and rdy_i=1 → output 0x08, then 0x01..0x08. last_o only on 0x08. idle_o returns to 1.
- Push 8 ZNZ and 8 BPC words in the same cycles → ZNZ frame (hdr 0x08) first, then BPC frame (hdr 0x88). rr ends pointing to ZNZ.
- Push 3 BPC words 0xA1,0xA2,0xA3, then assert enc_idle_i → hdr 0x83, 0xA1, 0xA2, 0xA3 with last_o on 0xA3.
- Hold rdy_i=0 for 5 cycles during HDR and PAY → data_o/vld_o/last_o stable. Pushing 16 BPC words deasserts bpc_rdy_o after the 16th; one pop re-asserts it the next cycle.
- Push 20 ZNZ words with enc_idle_i=1 at the end → frames of 8, 8, then flush frame hdr 0x04 with the remaining 4 words. Output order is preserved.
- Assert rst_ni low during the PAY of a BPC frame → vld_o=0 immediately. After release, idle_o=1, FIFOs empty, no stale words emitted.
